cmd_sched: RTL

//  Parametrised command scheduler: successor to the single-op control/status block.

---
 rtl/csb_pkg.sv | 40 ++++
 rtl/cmd_fifo.sv | 53 +++++
 rtl/cmd_sched.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/csb_pkg.sv
// ----------------------------------------------------------------------------
// Module : csb_pkg
// Brief  : Op codes, engine indices, FSM encoding and op decode for cmd_sched.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

package csb_pkg;

   localparam logic [2:0] OP_CONV1X1   = 3'b001;
   localparam logic [2:0] OP_CONV3X3   = 3'b010;
   localparam logic [2:0] OP_POOL3X3   = 3'b011;
   localparam logic [2:0] OP_POOL13X13 = 3'b100;

   localparam int ENG_CONV = 0;
   localparam int ENG_P3   = 1;
   localparam int ENG_P13  = 2;
   localparam int NUM_ENG  = 3;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DECODE = 2'd1;
   localparam logic [1:0] S_BUSY   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // One-hot engine select; all-zero marks an illegal op.
   function automatic logic [NUM_ENG-1:0] op_eng_sel(input logic [2:0] op);
      logic [NUM_ENG-1:0] sel;
      sel = '0;
      case (op)
         OP_CONV1X1, OP_CONV3X3: sel[ENG_CONV] = 1'b1;
         OP_POOL3X3:             sel[ENG_P3]   = 1'b1;
         OP_POOL13X13:           sel[ENG_P13]  = 1'b1;
         default:                sel           = '0;
      endcase
      return sel;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_fifo.sv
// ----------------------------------------------------------------------------
// Module : cmd_fifo
// Brief  : Synchronous command FIFO with first-word fall-through read data.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]      r_wptr;
   logic [PW:0]      r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   assign empty     = (r_wptr == r_rptr);
   assign full      = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
   assign w_do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push while full still lands.
   assign w_do_push = push & (~full | w_do_pop);
   assign data_out  = r_mem[r_rptr[PW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + (PW+1)'(1);
         if (w_do_pop)  r_rptr <= r_rptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr[PW-1:0]] <= data_in;
   end

endmodule

`default_nettype wire

// File: rtl/cmd_sched.sv
// ----------------------------------------------------------------------------
// Module : cmd_sched
// Brief  : Queued command scheduler: decode, engine go/done, DMA enables, watchdog.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module cmd_sched
   import csb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int LW      = 8,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 65535,
   parameter int CNTW    = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [2:0]      cmd_op,
   input  logic [AW-1:0]   cmd_raddr,
   input  logic [AW-1:0]   cmd_waddr,
   input  logic [LW-1:0]   cmd_len,
   output logic [2:0]      eng_go,
   input  logic [2:0]      eng_done,
   output logic            conv_k3,
   output logic            dma_re,
   output logic            dma_we,
   output logic            dma_aux_re,
   output logic            dma_aux_we,
   output logic [AW-1:0]   r_addr,
   output logic [LW-1:0]   r_len,
   output logic [AW-1:0]   w_addr,
   output logic            busy,
   output logic            irq,
   output logic            err,
   output logic [CNTW-1:0] done_cnt
);

   localparam int          FW        = 3 + 2*AW + LW;
   localparam logic [31:0] c_WD_LAST = 32'(TIMEOUT - 1);

   logic [1:0]    r_state;
   logic [2:0]    r_op;
   logic [31:0]   r_wd;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic [FW-1:0] w_fifo_in;
   logic [FW-1:0] w_fifo_out;
   logic [2:0]    w_sel;
   logic          w_done_hit;
   logic          w_wd_expire;

   assign cmd_ready   = ~w_full;
   assign w_push      = cmd_valid & cmd_ready;
   assign w_pop       = (r_state == S_IDLE) & ~w_empty;
   assign w_fifo_in   = {cmd_op, cmd_raddr, cmd_waddr, cmd_len};
   assign busy        = (r_state != S_IDLE) | ~w_empty;
   assign w_sel       = op_eng_sel(r_op);
   assign w_done_hit  = |(eng_done & eng_go);
   assign w_wd_expire = (TIMEOUT != 0) && (r_wd == c_WD_LAST);

   cmd_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (w_push),
      .pop      (w_pop),
      .data_in  (w_fifo_in),
      .data_out (w_fifo_out),
      .full     (w_full),
      .empty    (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_wd       <= '0;
         r_addr     <= '0;
         r_len      <= '0;
         w_addr     <= '0;
         eng_go     <= '0;
         conv_k3    <= 1'b0;
         dma_re     <= 1'b0;
         dma_we     <= 1'b0;
         dma_aux_re <= 1'b0;
         dma_aux_we <= 1'b0;
         irq        <= 1'b0;
         err        <= 1'b0;
         done_cnt   <= '0;
      end else begin
         irq <= 1'b0;
         err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  {r_op, r_addr, w_addr, r_len} <= w_fifo_out;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (w_sel == 3'b000) begin
                  err     <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  eng_go     <= w_sel;
                  conv_k3    <= (r_op == OP_CONV3X3);
                  dma_re     <= (r_op == OP_CONV1X1);
                  dma_we     <= (r_op == OP_CONV1X1);
                  dma_aux_re <= (r_op != OP_CONV1X1);
                  dma_aux_we <= (r_op != OP_CONV1X1);
                  r_wd       <= '0;
                  r_state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               // Completion is checked first so it wins over a coincident expiry.
               if (w_done_hit || w_wd_expire) begin
                  eng_go     <= '0;
                  conv_k3    <= 1'b0;
                  dma_re     <= 1'b0;
                  dma_we     <= 1'b0;
                  dma_aux_re <= 1'b0;
                  dma_aux_we <= 1'b0;
                  if (w_done_hit) begin
                     irq      <= 1'b1;
                     done_cnt <= done_cnt + CNTW'(1);
                     r_state  <= S_DONE;
                  end else begin
                     err     <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_wd <= r_wd + 32'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
